// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode/funct3 constants and the decoded-control types
// used by the issue stage, the ALU and the forwarding unit.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_ctrl_t;

  typedef struct packed {
    logic        valid;
    alu_ctrl_e   alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } ex_reg_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of the ALU-relevant RV32I subset into ALU control,
// operand values, register indices and write/memory flags.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output dec_ctrl_t   o_dec
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  dec_ctrl_t  w_dec;

  assign w_op   = i_instr[6:0];
  assign w_f3   = i_instr[14:12];
  assign w_f7b5 = i_instr[30];

  always_comb begin
    w_dec           = '0;
    w_dec.alu_ctrl  = ALU_ADD;
    w_dec.src_a     = i_rs1_data;
    w_dec.src_b     = i_rs2_data;
    w_dec.rd        = i_instr[11:7];
    w_dec.rs1_used  = 1'b1;
    w_dec.rs2_used  = 1'b1;

    case (w_op)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        case (w_f3)
          F3_ADD:  w_dec.alu_ctrl = w_f7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  w_dec.alu_ctrl = ALU_AND;
          F3_OR:   w_dec.alu_ctrl = ALU_OR;
          F3_SLT:  w_dec.alu_ctrl = ALU_SLT;
          default: w_dec.illegal  = 1'b1;
        endcase
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.rs2_used  = 1'b0;
        w_dec.src_b     = sext12(i_instr[31:20]);
        case (w_f3)
          F3_ADD:  w_dec.alu_ctrl = ALU_ADD;
          F3_SLT:  w_dec.alu_ctrl = ALU_SLT;
          F3_OR:   w_dec.alu_ctrl = ALU_OR;
          F3_AND:  w_dec.alu_ctrl = ALU_AND;
          default: w_dec.illegal  = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_dec.rs2_used  = 1'b0;
        w_dec.src_b     = sext12(i_instr[31:20]);
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.illegal   = (w_f3 != F3_LW);
      end
      OP_STORE: begin
        w_dec.src_b     = sext12({i_instr[31:25], i_instr[11:7]});
        w_dec.mem_write = 1'b1;
        w_dec.illegal   = (w_f3 != F3_SW);
      end
      OP_BRANCH: begin
        w_dec.alu_ctrl = ALU_SUB;
        w_dec.illegal  = (w_f3 != F3_BEQ);
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.rs1_used  = 1'b0;
        w_dec.rs2_used  = 1'b0;
        w_dec.src_a     = '0;
        w_dec.src_b     = {i_instr[31:12], 12'b0};
      end
      default: w_dec.illegal = 1'b1;
    endcase

    // Illegal encodings fall back to a harmless add that reads both sources.
    if (w_dec.illegal) begin
      w_dec.alu_ctrl  = ALU_ADD;
      w_dec.src_a     = i_rs1_data;
      w_dec.src_b     = i_rs2_data;
      w_dec.rs1_used  = 1'b1;
      w_dec.rs2_used  = 1'b1;
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
    end

    if (w_dec.rd == 5'd0) w_dec.reg_write = 1'b0;

    // Unused sources report index 0 so the forwarding unit never matches them.
    w_dec.rs1 = w_dec.rs1_used ? i_instr[19:15] : 5'd0;
    w_dec.rs2 = w_dec.rs2_used ? i_instr[24:20] : 5'd0;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ID instruction, detects load-use hazards and
// registers the ALU controls and operands into the ID/EX pipeline register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit LOAD_USE_DETECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall_in,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_src_a,
  output logic [XLEN-1:0] ex_src_b,
  output logic [2:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  dec_ctrl_t w_dec;
  ex_reg_t   w_next;
  ex_reg_t   r_ex;
  logic      w_rs1_hit;
  logic      w_rs2_hit;
  logic      w_hz;

  alu_decoder u_dec (
    .i_instr    (id_instr),
    .i_rs1_data (id_rs1_data),
    .i_rs2_data (id_rs2_data),
    .o_dec      (w_dec)
  );

  assign w_rs1_hit = w_dec.rs1_used && (r_ex.rd == id_instr[19:15]);
  assign w_rs2_hit = w_dec.rs2_used && (r_ex.rd == id_instr[24:20]);
  assign w_hz      = LOAD_USE_DETECT && id_valid && r_ex.valid && r_ex.mem_read &&
                     (r_ex.rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
  assign id_stall  = (w_hz || stall_in) && !flush;

  always_comb begin
    w_next           = '0;
    w_next.valid     = 1'b1;
    w_next.alu_ctrl  = w_dec.alu_ctrl;
    w_next.src_a     = w_dec.src_a;
    w_next.src_b     = w_dec.src_b;
    w_next.rs2_data  = id_rs2_data;
    w_next.pc        = id_pc;
    w_next.rd        = w_dec.rd;
    w_next.rs1       = w_dec.rs1;
    w_next.rs2       = w_dec.rs2;
    w_next.reg_write = w_dec.reg_write;
    w_next.mem_read  = w_dec.mem_read;
    w_next.mem_write = w_dec.mem_write;
    w_next.illegal   = w_dec.illegal;
  end

  // Flush beats stall; a hazard inserts a bubble while ID re-presents its instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex <= '0;
    end else if (stall_in) begin
      r_ex <= r_ex;
    end else if (w_hz || !id_valid) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_next;
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_src_a       = r_ex.src_a;
  assign ex_src_b       = r_ex.src_b;
  assign ex_alu_control = r_ex.alu_ctrl;
  assign ex_rs2_data    = r_ex.rs2_data;
  assign ex_pc          = r_ex.pc;
  assign ex_rd          = r_ex.rd;
  assign ex_rs1         = r_ex.rs1;
  assign ex_rs2         = r_ex.rs2;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign ex_illegal     = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference model predicts id_stall and the
// next EX contents; a monitor compares them on the falling edge.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  ctrl;
    logic [31:0] rs2d;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_src_a, ex_src_b, ex_rs2_data, ex_pc;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  ex_t  w_act;
  ex_t  q_ex[$];
  bit   q_st[$];
  ex_t  m_ex;
  bit   m_last_stall;
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_issue_stage #(.XLEN(32), .LOAD_USE_DETECT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall_in(stall_in), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_alu_control(ex_alu_control), .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  assign w_act = {ex_valid, ex_src_a, ex_src_b, ex_alu_control, ex_rs2_data, ex_pc,
                  ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal};

  // Reference: what the instruction means, independent of how the RTL decodes it.
  function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output ex_t e, output bit u1, output bit u2);
    int   op, f3;
    bit   legal, rw, mr, mw;
    logic [2:0]  ctrl;
    logic [31:0] sa, sb, iimm, simm;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    iimm = {{20{ins[31]}}, ins[31:20]};
    simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    legal = 1; rw = 0; mr = 0; mw = 0; ctrl = 3'd0; sa = a; sb = b; u1 = 1; u2 = 1;
    if (op == 'h33 && f3 inside {0, 2, 6, 7}) begin
      rw = 1;
      ctrl = (f3 == 0) ? (ins[30] ? 3'd1 : 3'd0) : (f3 == 7) ? 3'd2 : (f3 == 6) ? 3'd3 : 3'd5;
    end else if (op == 'h13 && f3 inside {0, 2, 6, 7}) begin
      rw = 1; sb = iimm; u2 = 0;
      ctrl = (f3 == 0) ? 3'd0 : (f3 == 2) ? 3'd5 : (f3 == 6) ? 3'd3 : 3'd2;
    end else if (op == 'h03 && f3 == 2) begin
      rw = 1; mr = 1; sb = iimm; u2 = 0;
    end else if (op == 'h23 && f3 == 2) begin
      mw = 1; sb = simm;
    end else if (op == 'h63 && f3 == 0) begin
      ctrl = 3'd1;
    end else if (op == 'h37) begin
      rw = 1; sa = 0; sb = ins & 32'hFFFF_F000; u1 = 0; u2 = 0;
    end else begin
      legal = 0;
    end
    e.valid = 1'b1;
    e.src_a = sa;
    e.src_b = sb;
    e.ctrl  = ctrl;
    e.rs2d  = b;
    e.pc    = pc;
    e.rd    = ins[11:7];
    e.rs1   = u1 ? ins[19:15] : 5'd0;
    e.rs2   = u2 ? ins[24:20] : 5'd0;
    e.rw    = rw && (ins[11:7] != 0);
    e.mr    = mr;
    e.mw    = mw;
    e.ill   = !legal;
  endfunction

  // Drive one ID cycle and push the model's predictions for it.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input bit st, input bit fl);
    ex_t dec, nxt;
    bit  u1, u2, hz, stl;
    @(posedge clk);
    #2;
    id_valid = v; id_instr = ins; id_pc = pc; id_rs1_data = a; id_rs2_data = b;
    stall_in = st; flush = fl;
    ref_dec(ins, pc, a, b, dec, u1, u2);
    hz = v && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
         ((u1 && m_ex.rd == ins[19:15]) || (u2 && m_ex.rd == ins[24:20]));
    stl = (hz || st) && !fl;
    if (fl)           nxt = '0;
    else if (st)      nxt = m_ex;
    else if (hz || !v) nxt = '0;
    else              nxt = dec;
    q_st.push_back(stl);
    q_ex.push_back(nxt);
    m_ex = nxt;
    m_last_stall = stl;
  endtask

  // Present an instruction until the stage accepts it, as the IF/ID stage would.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    do begin
      cycle(1'b1, ins, pc, a, b, 1'b0, 1'b0);
      n++;
    end while (m_last_stall && n < 4);
    if (m_last_stall) begin
      errors++;
      $display("FAIL issue_bound instr=%h still stalled after %0d cycles, required accept", ins, n);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 3));
    r1  = 5'($urandom_range(0, 3));
    r2  = 5'($urandom_range(0, 3));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 8))
      0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'b0110011};
      1: return {imm, r1, f3, rd, 7'b0010011};
      2, 3: return {imm, r1, ($urandom_range(0, 5) == 0) ? f3 : 3'b010, rd, 7'b0000011};
      4: return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
      5: return {7'h00, r2, r1, 3'b000, rd, 7'b1100011};
      6: return {20'($urandom), rd, 7'b0110111};
      7: return {7'h00, r2, r1, 3'b000, rd, 7'b0110011};
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    ex_t e;
    bit  s;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q_st.size() > 0) begin
          s = q_st.pop_front();
          checks++;
          if (id_stall !== s) begin
            errors++;
            $display("FAIL id_stall t=%0t actual=%b required=%b", $time, id_stall, s);
          end
        end
        if (q_ex.size() >= 2) begin
          e = q_ex.pop_front();
          checks++;
          if (w_act !== e) begin
            errors++;
            $display("FAIL ex_regs t=%0t actual=%h required=%h", $time, w_act, e);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] ins;
    bit st, fl, v;
    m_ex = '0;
    m_last_stall = 1'b0;
    #12;
    checks++;
    if (w_act !== '0) begin
      errors++; $display("FAIL reset_ex actual=%h required=0", w_act);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall actual=%b required=0", id_stall);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(32'h402081B3, 32'h100, 32'd10, 32'd3);          // sub x3,x1,x2
    issue(32'hFFF00293, 32'h104, 32'd7, 32'd9);           // addi x5,x0,-1
    issue(32'h123453B7, 32'h108, 32'hDEAD, 32'hBEEF);     // lui x7,0x12345
    issue(32'h00012083, 32'h10C, 32'h40, 32'h0);          // lw x1,0(x2)
    issue(32'h004081B3, 32'h110, 32'h11, 32'h22);         // add x3,x1,x4 -> one bubble
    issue(32'h00012003, 32'h114, 32'h40, 32'h0);          // lw x0,0(x2)
    issue(32'h004001B3, 32'h118, 32'h0, 32'h22);          // add x3,x0,x4 -> no stall
    issue(32'h00012083, 32'h11C, 32'h40, 32'h0);          // lw x1
    cycle(1'b1, 32'h004081B3, 32'h120, 32'h1, 32'h2, 1'b1, 1'b1);  // flush+stall+hz
    cycle(1'b1, 32'h002081B3, 32'h124, 32'h5, 32'h6, 1'b1, 1'b0);  // stall holds bubble
    issue(32'h0000007F, 32'h128, 32'h3, 32'h4);           // illegal
    issue(32'h00C0A423, 32'h12C, 32'h80, 32'h55);         // sw x12,8(x1)
    issue(32'h00208463, 32'h130, 32'h9, 32'h9);           // beq x1,x2
    cycle(1'b1, 32'h402081B3, 32'h134, 32'h1, 32'h2, 1'b1, 1'b0);

    ins = rand_instr();
    for (int i = 0; i < 500; i++) begin
      if (!m_last_stall) ins = rand_instr();
      v  = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 19) == 0);
      cycle(v, ins, 32'(4 * i), $urandom, $urandom, st, fl);
    end

    issue(32'h402081B3, 32'h200, 32'd10, 32'd3);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_act !== '0) begin
      errors++; $display("FAIL async_reset_ex actual=%h required=0", w_act);
    end
    q_ex.delete();
    q_st.delete();
    m_ex = '0;
    m_last_stall = 1'b0;
    id_valid = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 40; i++) begin
      if (!m_last_stall) ins = rand_instr();
      cycle(1'b1, ins, 32'(4 * i + 32'h300), $urandom, $urandom, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
